// File: rtl/soc_system_box_resp.sv
// Avalon-MM slave that returns HPS response words to fabric logic through a
// show-ahead FIFO, with status, sticky overflow and a handshake counter.
module soc_system_box_resp #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned CNT_W = 16;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_CTRL   = 3'd2;
   localparam logic [2:0] ADDR_COUNT  = 3'd3;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             enable;
   logic             ovf;
   logic [CNT_W-1:0] count;

   logic [PTR_W-1:0] wr_ptr_nxt;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic             enable_nxt;
   logic             ovf_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             out_valid_nxt;

   logic [PTR_W-1:0] level_c;
   logic             full_c;
   logic             empty_c;
   logic             wr_stb_c;
   logic             push_req_c;
   logic             push_c;
   logic             flush_c;
   logic             hs_c;
   logic [31:0]      rdata_c;
   logic             unused_wdata_c;

   // Bits above DATA_W only matter for CONTROL/STATUS decodes
   assign unused_wdata_c = ^writedata;

   // FIFO occupancy and event decode, all from pre-edge state
   always_comb begin
      level_c    = wr_ptr - rd_ptr;
      full_c     = (level_c == PTR_W'(DEPTH));
      empty_c    = (level_c == '0);
      wr_stb_c   = chipselect && !write_n;
      hs_c       = out_valid && out_ready;
      push_req_c = wr_stb_c && (address == ADDR_DATA);
      flush_c    = wr_stb_c && (address == ADDR_CTRL) && writedata[1];
      push_c     = push_req_c && !full_c && !flush_c;
   end

   // Next-state: flush overrides pop, counter clear overrides increment,
   // overflow set overrides overflow clear
   always_comb begin
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      enable_nxt    = enable;
      ovf_nxt       = ovf;
      count_nxt     = count;
      out_valid_nxt = 1'b0;

      if (push_c) begin
         wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end

      if (flush_c) begin
         rd_ptr_nxt = wr_ptr_nxt;
      end else if (hs_c) begin
         rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end

      if (wr_stb_c && (address == ADDR_STATUS) && writedata[2]) begin
         ovf_nxt = 1'b0;
      end
      if (push_req_c && full_c && !flush_c) begin
         ovf_nxt = 1'b1;
      end

      if (wr_stb_c && (address == ADDR_CTRL)) begin
         enable_nxt = writedata[0];
      end

      if (hs_c) begin
         count_nxt = count + CNT_W'(1);
      end
      if (wr_stb_c && (address == ADDR_COUNT)) begin
         count_nxt = '0;
      end

      out_valid_nxt = enable_nxt && (wr_ptr_nxt != rd_ptr_nxt);
   end

   // Read mux, sampled every edge regardless of chipselect
   always_comb begin
      rdata_c = '0;
      case (address)
         ADDR_DATA:   rdata_c = 32'(level_c);
         ADDR_STATUS: rdata_c = {16'd0, 8'(level_c), 5'd0, ovf, full_c, empty_c};
         ADDR_CTRL:   rdata_c = {31'd0, enable};
         ADDR_COUNT:  rdata_c = {16'd0, count};
         default:     rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         enable    <= 1'b0;
         ovf       <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         readdata  <= '0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         enable    <= enable_nxt;
         ovf       <= ovf_nxt;
         count     <= count_nxt;
         out_valid <= out_valid_nxt;
         readdata  <= rdata_c;
      end
   end

   // Storage is cleared on reset so the head word reads 0 out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (push_c) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= writedata[DATA_W-1:0];
      end
   end

   assign out_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: doc/soc_system_box_resp.md
# soc_system_box_resp

Avalon-MM slave that carries HPS responses back to fabric logic, the return path for the box-request input port. The HPS writes response words into a small FIFO through the lightweight bridge. The block presents them to the fabric consumer over a valid/ready stream. It also keeps status, a sticky overflow flag, and a handshake counter for software polling.

## Interface
- DATA_W, 16, response word width (1..32)
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (1..7)

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low; clock clk
- address  in  3  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- out_data  out  DATA_W  FIFO head word
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts head word

## Operation
- Write strobe: chipselect && !write_n, per address.
- addr 0 DATA
  - Write: push writedata[DATA_W-1:0] if not full.
  - If full: word dropped, ovf set to 1.
  - Read: {zero-extended level}.
- addr 1 STATUS (read): bit0 empty, bit1 full, bit2 ovf, bits[15:8] level (0..DEPTH), others 0.
  - Write with writedata[2]=1: clear ovf.
- addr 2 CONTROL (read/write):
  - bit0 enable, reset 0.
  - bit1 flush: write-1 action, reads 0. Empties FIFO, leaves enable/ovf/count unchanged.
- addr 3 COUNT (read): 16-bit completed-handshake count, zero-extended, wraps 0xFFFF→0.
  - Write any value: clear to 0.
- addr 4..7: read 0, writes ignored.
- Stream outputs:
  - out_valid = enable && !empty.
  - out_data = head entry, show-ahead (first-word fall-through); out_data is don't-care when out_valid=0.
  - Handshake = out_valid && out_ready in the same cycle. Pops head, increments COUNT.
  - Disabling holds FIFO contents. No handshakes while enable=0.
- FIFO: circular buffer, read/write pointers DEPTH_LOG2+1 bits wide, level = wr_ptr − rd_ptr. Pointers wrap silently.
- Simultaneous events, same edge:
  - Push and handshake, not full: both occur, level unchanged.
  - Push while full with handshake: push dropped, ovf set. Full is evaluated on the pre-edge level.
  - Flush with push: flush wins, push discarded, ovf unaffected.
  - Flush with handshake: sink's transfer counts, COUNT increments, FIFO empty after the edge.
  - COUNT clear with handshake: clear wins, COUNT = 0.
  - ovf clear with overflowing push: set wins, ovf = 1.

## Timing
- Reset, asynchronous:
  - readdata = 0, out_valid = 0, out_data = 0.
  - Pointers 0, enable 0, ovf 0, COUNT 0.
- Reset mid-operation discards all FIFO contents immediately.
- Register update: all state updates on the clk edge where the strobe or handshake is sampled.
- readdata = read mux (address) sampled every edge, no read strobe. Latency 1 cycle, reflecting state as of the previous edge (read wait-states 1).
- Push-to-output: word written at edge N, enable=1, FIFO empty → out_valid=1 and out_data valid after edge N.
- Back-to-back: with out_ready held 1, one word per cycle.
- No combinational path from out_ready to out_valid or out_data. out_valid depends only on registered state.

## Test plan
- Reset, then read addr 1 → readdata 0x0000_0001 (empty). out_valid=0 with out_ready=1.
- Enable (addr2 ← 1). Push 0x1111, 0x2222, out_ready=0 → out_valid=1, out_data=0x1111, STATUS level=2. Then out_ready=1 for 2 cycles → 0x1111 then 0x2222 transfer, COUNT=2, empty=1.
- enable=0, push 5 words into DEPTH=4 → STATUS = 0x0000_0406 (level 4, full, ovf). Set enable=1 and drain → first four words, in order. Write addr1 ← 4 → ovf=0.
- Full FIFO, push and handshake on the same edge → pushed word lost, ovf=1, level=3. Push and pop at level 2 → level stays 2, order preserved.
- Level 3, write addr2 ← 3 (flush) while pushing on the next cycle → after flush level=0. The next push gives level=1. enable stays 1.
- Preload COUNT to 0xFFFF via 65535 handshakes (or force), one more handshake → COUNT=0. Write addr3 concurrent with a handshake → COUNT=0.
